// File: rtl/idelay_eye_scan.sv
`default_nettype none
// ============================================================================
// Module   : idelay_eye_scan
// Brief    : Sweeps an input-delay tap range, finds the widest error-free
//            window against a training pattern and loads its centre tap.
// Revision : 1.0 - initial release
// ============================================================================
module idelay_eye_scan #(
    parameter int                TAP_MAX       = 511,
    parameter int                TAP_STEP      = 8,
    parameter int                WORD_W        = 8,
    parameter logic [WORD_W-1:0] TRAIN_PATTERN = 8'hA5,
    parameter int                SAMPLE_WORDS  = 256,
    parameter int                SETTLE_CYCLES = 16,
    parameter int                ACK_TIMEOUT   = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [8:0]        tap_value,
    input  logic              tap_done,
    input  logic              data_valid,
    input  logic [WORD_W-1:0] data_word,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [8:0]        best_tap,
    output logic [8:0]        window_len
);

    localparam logic [9:0]  c_tap_max      = 10'(TAP_MAX);
    localparam logic [9:0]  c_tap_step     = 10'(TAP_STEP);
    localparam logic [15:0] c_sample_words = 16'(SAMPLE_WORDS);
    localparam logic [15:0] c_settle_last  = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] c_ack_timeout  = 16'(ACK_TIMEOUT);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        SET_TAP   = 4'd1,
        WAIT_ACK  = 4'd2,
        SETTLE    = 4'd3,
        SAMPLE    = 4'd4,
        EVAL      = 4'd5,
        APPLY     = 4'd6,
        APPLY_ACK = 4'd7,
        FINISH    = 4'd8
    } state_t;

    state_t      r_state, w_state_nx;
    logic [8:0]  r_tap_value, r_cur_tap, r_best_tap, r_window_len;
    logic        r_busy, r_done, r_fail;
    logic [15:0] r_ack_timer, r_settle_cnt, r_word_cnt, r_err_cnt;
    logic [1:0]  r_blank;
    logic [8:0]  r_run_start, r_best_start;
    logic [9:0]  r_run_len, r_best_len;

    logic        w_ack, w_timeout, w_pass, w_last, w_close;
    logic [9:0]  w_next;
    logic [8:0]  w_new_start, w_close_start, w_center;
    logic [9:0]  w_new_len, w_close_len;
    logic [15:0] w_half;

    // The sequencer's done lags a tap change by a registered cycle, so the
    // first two cycles after a new request cannot be trusted.
    assign w_ack     = (r_blank == 2'd2) && tap_done;
    assign w_timeout = (r_ack_timer >= c_ack_timeout);

    assign w_pass      = (r_err_cnt == 16'd0);
    assign w_next      = {1'b0, r_cur_tap} + c_tap_step;
    assign w_last      = (w_next > c_tap_max);
    assign w_new_start = (r_run_len == 10'd0) ? r_cur_tap : r_run_start;
    assign w_new_len   = r_run_len + 10'd1;
    // A run still open at the end of the sweep is closed with this point included.
    assign w_close       = !w_pass || w_last;
    assign w_close_start = w_pass ? w_new_start : r_run_start;
    assign w_close_len   = w_pass ? w_new_len : r_run_len;

    assign w_half   = ((16'(r_best_len) - 16'd1) * 16'(TAP_STEP)) >> 1;
    assign w_center = r_best_start + 9'(w_half);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE:      if (start) w_state_nx = SET_TAP;
            SET_TAP:   w_state_nx = WAIT_ACK;
            WAIT_ACK: begin
                if (w_ack)          w_state_nx = SETTLE;
                else if (w_timeout) w_state_nx = IDLE;
            end
            SETTLE:    if (r_settle_cnt >= c_settle_last) w_state_nx = SAMPLE;
            SAMPLE:    if (r_word_cnt == c_sample_words) w_state_nx = EVAL;
            EVAL:      w_state_nx = w_last ? APPLY : SET_TAP;
            APPLY:     w_state_nx = (r_best_len == 10'd0) ? FINISH : APPLY_ACK;
            APPLY_ACK: begin
                if (w_ack)          w_state_nx = FINISH;
                else if (w_timeout) w_state_nx = IDLE;
            end
            FINISH:    w_state_nx = IDLE;
            default:   w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tap_value  <= 9'd0;
            r_cur_tap    <= 9'd0;
            r_best_tap   <= 9'd0;
            r_window_len <= 9'd0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_fail       <= 1'b0;
            r_ack_timer  <= 16'd0;
            r_settle_cnt <= 16'd0;
            r_word_cnt   <= 16'd0;
            r_err_cnt    <= 16'd0;
            r_blank      <= 2'd0;
            r_run_start  <= 9'd0;
            r_run_len    <= 10'd0;
            r_best_start <= 9'd0;
            r_best_len   <= 10'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_busy       <= 1'b1;
                        r_done       <= 1'b0;
                        r_fail       <= 1'b0;
                        r_best_tap   <= 9'd0;
                        r_window_len <= 9'd0;
                        r_cur_tap    <= 9'd0;
                        r_run_start  <= 9'd0;
                        r_run_len    <= 10'd0;
                        r_best_start <= 9'd0;
                        r_best_len   <= 10'd0;
                    end
                end
                SET_TAP: begin
                    r_tap_value <= r_cur_tap;
                    r_ack_timer <= 16'd0;
                    r_blank     <= 2'd0;
                end
                WAIT_ACK, APPLY_ACK: begin
                    r_ack_timer  <= r_ack_timer + 16'd1;
                    r_settle_cnt <= 16'd0;
                    if (r_blank != 2'd2) r_blank <= r_blank + 2'd1;
                    if (!w_ack && w_timeout) begin
                        r_fail <= 1'b1;
                        r_done <= 1'b1;
                        r_busy <= 1'b0;
                    end
                end
                SETTLE: begin
                    r_settle_cnt <= r_settle_cnt + 16'd1;
                    r_word_cnt   <= 16'd0;
                    r_err_cnt    <= 16'd0;
                end
                SAMPLE: begin
                    if (r_word_cnt != c_sample_words && data_valid) begin
                        r_word_cnt <= r_word_cnt + 16'd1;
                        if (data_word != TRAIN_PATTERN && r_err_cnt != 16'hFFFF)
                            r_err_cnt <= r_err_cnt + 16'd1;
                    end
                end
                EVAL: begin
                    if (w_close && (w_close_len > r_best_len)) begin
                        r_best_start <= w_close_start;
                        r_best_len   <= w_close_len;
                    end
                    r_run_start <= w_new_start;
                    r_run_len   <= w_pass ? w_new_len : 10'd0;
                    if (!w_last) r_cur_tap <= w_next[8:0];
                end
                APPLY: begin
                    if (r_best_len == 10'd0) begin
                        r_fail       <= 1'b1;
                        r_best_tap   <= 9'd0;
                        r_window_len <= 9'd0;
                    end else begin
                        r_best_tap   <= w_center;
                        r_window_len <= 9'(r_best_len);
                        r_tap_value  <= w_center;
                        r_ack_timer  <= 16'd0;
                        r_blank      <= 2'd0;
                    end
                end
                FINISH: begin
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign tap_value  = r_tap_value;
    assign busy       = r_busy;
    assign done       = r_done;
    assign fail       = r_fail;
    assign best_tap   = r_best_tap;
    assign window_len = r_window_len;

endmodule
`default_nettype wire

// File: tb/tb_idelay_eye_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_idelay_eye_scan
// Brief    : Scoreboard bench for idelay_eye_scan with a delay-sequencer model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_idelay_eye_scan;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [8:0] tap_value;
    logic       tap_done;
    logic       data_valid;
    logic [7:0] data_word;
    logic       busy, done, fail;
    logic [8:0] best_tap, window_len;

    always #5 clk = ~clk;

    idelay_eye_scan #(.SAMPLE_WORDS(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .tap_value(tap_value),
        .tap_done(tap_done), .data_valid(data_valid), .data_word(data_word),
        .busy(busy), .done(done), .fail(fail), .best_tap(best_tap),
        .window_len(window_len)
    );

    typedef struct {
        logic       fail;
        logic [8:0] best;
        logic [8:0] wlen;
        logic [8:0] tapv;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    int   pmode = 0;   // which taps see a clean training word
    int   vmode = 1;   // 0: never valid, 1: always valid, 2: every other cycle
    bit   hold_low = 1'b0;
    bit   tog = 1'b0;
    logic [8:0] seq_last = 9'd0;
    bit   seq_ok = 1'b1;
    int   seq_cnt = 0;

    function automatic bit tap_pass(int t, int m);
        case (m)
            0: return 1'b1;
            1: return (t >= 96) && (t < 304);
            2: return (t <= 56) || ((t >= 200) && (t <= 256));
            default: return 1'b0;
        endcase
    endfunction

    // Delay-sequencer and lane model: done drops after a tap change and
    // returns a few cycles later; the lane word depends on the applied tap.
    always @(negedge clk) begin
        if (tap_value != seq_last) begin
            seq_last = tap_value;
            seq_ok   = 1'b0;
            seq_cnt  = 3;
        end else if (seq_cnt != 0) begin
            seq_cnt = seq_cnt - 1;
        end else begin
            seq_ok = 1'b1;
        end
        tap_done = seq_ok && !hold_low;
        tog = ~tog;
        data_valid = (vmode == 1) ? 1'b1 : (vmode == 2) ? tog : 1'b0;
        data_word  = tap_pass(int'(tap_value), pmode) ? 8'hA5 : 8'h5A;
    end

    function automatic exp_t model(int m);
        exp_t e;
        int rs = 0, rl = 0, bs = 0, bl = 0;
        for (int t = 0; t <= 511; t += 8) begin
            if (tap_pass(t, m)) begin
                if (rl == 0) rs = t;
                rl++;
            end else begin
                if (rl > bl) begin bl = rl; bs = rs; end
                rl = 0;
            end
        end
        if (rl > bl) begin bl = rl; bs = rs; end
        if (bl == 0) begin
            e.fail = 1'b1; e.best = 9'd0; e.wlen = 9'd0; e.tapv = 9'd504;
        end else begin
            e.fail = 1'b0;
            e.best = 9'(bs + (((bl - 1) * 8) >> 1));
            e.wlen = 9'(bl);
            e.tapv = e.best;
        end
        return e;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check_val("busy_after_start", busy, 1);
        check_val("done_cleared", done, 0);
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (done && !busy) begin ok = 1'b1; break; end
        end
    endtask

    task automatic finish_check(input string tag, input int budget);
        exp_t e;
        bit ok;
        wait_done(budget, ok);
        check_val({tag, "_in_time"}, ok, 1);
        e = sb.pop_front();
        check_val({tag, "_done"}, done, 1);
        check_val({tag, "_busy"}, busy, 0);
        check_val({tag, "_fail"}, fail, e.fail);
        check_val({tag, "_best_tap"}, best_tap, e.best);
        check_val({tag, "_window_len"}, window_len, e.wlen);
        check_val({tag, "_tap_value"}, tap_value, e.tapv);
    endtask

    task automatic run_scan(input string tag, input int pm, input int vm, input int budget);
        pmode = pm;
        vmode = vm;
        sb.push_back(model(pm));
        do_start();
        finish_check(tag, budget);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_tap_value"}, tap_value, 0);
        check_val({tag, "_busy"}, busy, 0);
        check_val({tag, "_done"}, done, 0);
        check_val({tag, "_fail"}, fail, 0);
        check_val({tag, "_best_tap"}, best_tap, 0);
        check_val({tag, "_window_len"}, window_len, 0);
    endtask

    initial begin
        exp_t e;
        bit ok;
        rst_n = 1'b0;
        start = 1'b0;
        repeat (4) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Clean eye; a second start mid-scan must not restart the sweep,
        // which would push completion well past the budget.
        pmode = 0; vmode = 1;
        sb.push_back(model(0));
        do_start();
        repeat (1500) @(negedge clk);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        check_val("busy_ignore_start", busy, 1);
        finish_check("all_pass", 1800);

        repeat (20) @(negedge clk);
        check_val("hold_done", done, 1);
        check_val("hold_best_tap", best_tap, 252);

        run_scan("window_96_296", 1, 1, 4000);
        run_scan("two_equal", 2, 1, 4000);
        run_scan("no_pass", 3, 1, 4000);
        run_scan("toggle_valid", 1, 2, 8000);

        // Sequencer never acknowledges.
        hold_low = 1'b1;
        pmode = 0; vmode = 1;
        e.fail = 1'b1; e.best = 9'd0; e.wlen = 9'd0; e.tapv = 9'd0;
        sb.push_back(e);
        do_start();
        finish_check("ack_timeout", 3000);
        hold_low = 1'b0;
        repeat (5) @(negedge clk);

        // Stall mid-SAMPLE with no valid data, then reset asynchronously.
        pmode = 0; vmode = 1;
        do_start();
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (tap_value == 9'd80) begin ok = 1'b1; break; end
        end
        check_val("reach_tap80", ok, 1);
        repeat (25) @(negedge clk);
        vmode = 0;
        repeat (200) @(negedge clk);
        check_val("stall_busy", busy, 1);
        check_val("stall_done", done, 0);
        check_val("stall_tap", tap_value, 80);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        @(negedge clk) rst_n = 1'b1;
        repeat (6) @(negedge clk);

        run_scan("after_reset", 2, 1, 4000);

        check_val("scoreboard_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
